// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment driver: prescaled digit scan, frame-synchronous data commit,
// per-digit decimal points, leading-zero blanking and display enable.
module sevenseg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            catode
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_MAX = IW'(DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_index;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend_flag;
    logic [4*DIGITS-1:0]   r_disp_data;
    logic [DIGITS-1:0]     r_disp_dp;
    logic [DIGITS-1:0]     r_anode;
    logic [7:0]            r_catode;

    logic                  w_tick;
    logic                  w_boundary;
    logic [DIGITS-1:0]     w_lz;
    logic [3:0]            w_nibble;
    logic                  w_dp_bit;
    logic                  w_blank;
    logic [6:0]            w_seg;

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_boundary = w_tick && (r_index == INDEX_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_index <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_index <= (r_index == INDEX_MAX) ? '0 : r_index + 1'b1;
        end
    end

    // A load coinciding with the frame boundary bypasses the pending stage entirely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
        end else if (w_boundary) begin
            r_pend_flag <= 1'b0;
            if (load) begin
                r_disp_data <= data;
                r_disp_dp   <= dp;
            end else if (r_pend_flag) begin
                r_disp_data <= r_pend_data;
                r_disp_dp   <= r_pend_dp;
            end
        end else if (load) begin
            r_pend_data <= data;
            r_pend_dp   <= dp;
            r_pend_flag <= 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit blanks while everything above it is zero.
    always_comb begin : lz_scan
        logic w_zero_above;
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_disp_data[4*i +: 4] == 4'h0);
            w_lz[i]      = w_zero_above && (i != 0);
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_nibble = 4'h0;
        w_dp_bit = 1'b0;
        w_blank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_index == IW'(i)) begin
                w_nibble = r_disp_data[4*i +: 4];
                w_dp_bit = r_disp_dp[i];
                w_blank  = blank_lz && w_lz[i];
            end
        end
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_nibble)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anode  <= '1;
            r_catode <= 8'hFF;
        end else if (enable) begin
            r_anode  <= ~(DIGITS'(1) << r_index);
            r_catode <= {~w_dp_bit, (w_blank ? 7'h7F : w_seg)};
        end else begin
            r_anode  <= '1;
            r_catode <= 8'hFF;
        end
    end

    assign anode  = r_anode;
    assign catode = r_catode;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a 4-digit/div-4 and an 8-digit/div-1 instance share stimulus,
// a time-based reference model queues expected outputs and per-instance monitors compare them.
module tb_sevenseg_scan;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] ca;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data32;
    logic [7:0]  dp8;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  anode_a;
    logic [7:0]  catode_a;
    logic [7:0]  anode_b;
    logic [7:0]  catode_b;

    int n_checks = 0;
    int n_errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] seen_a [4];

    // Model state per instance: 0 = 4 digits / div 4, 1 = 8 digits / div 1
    logic [31:0] m_disp [2];
    logic [31:0] m_pend [2];
    logic [7:0]  m_dpd  [2];
    logic [7:0]  m_dpp  [2];
    bit          m_pf   [2];
    int          m_t    [2];

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    sevenseg_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .data(data32[15:0]), .dp(dp8[3:0]), .load(load),
        .blank_lz(blank_lz), .enable(enable), .anode(anode_a), .catode(catode_a)
    );

    sevenseg_scan #(.DIGITS(8), .REFRESH_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .data(data32), .dp(dp8), .load(load),
        .blank_lz(blank_lz), .enable(enable), .anode(anode_b), .catode(catode_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_dig(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int n_div(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t       e;
        int         idx;
        logic [7:0] mask;
        logic [3:0] nib;
        bit         blanked;
        mask = (k == 0) ? 8'h0F : 8'hFF;
        idx  = (m_t[k] / n_div(k)) % n_dig(k);
        nib  = 4'((m_disp[k] >> (4 * idx)) & 32'hF);
        blanked = blank_lz && (idx >= 1) && ((m_disp[k] >> (4 * idx)) == 32'h0);
        if (!enable) begin
            e.an = mask;
            e.ca = 8'hFF;
        end else begin
            e.an = ~(8'd1 << idx) & mask;
            e.ca = {~m_dpd[k][idx], (blanked ? 7'h7F : seg_tbl[nib][6:0])};
        end
        return e;
    endfunction

    function automatic void model_upd(input int k);
        logic [31:0] d;
        logic [7:0]  p;
        bit          boundary;
        d = (k == 0) ? (data32 & 32'h0000FFFF) : data32;
        p = (k == 0) ? (dp8 & 8'h0F) : dp8;
        boundary = (m_t[k] % (n_dig(k) * n_div(k))) == (n_dig(k) * n_div(k) - 1);
        if (boundary) begin
            if (load) begin
                m_disp[k] = d;
                m_dpd[k]  = p;
            end else if (m_pf[k]) begin
                m_disp[k] = m_pend[k];
                m_dpd[k]  = m_dpp[k];
            end
            m_pf[k] = 1'b0;
        end else if (load) begin
            m_pend[k] = d;
            m_dpp[k]  = p;
            m_pf[k]   = 1'b1;
        end
        m_t[k]++;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_disp[k] = '0; m_pend[k] = '0; m_dpd[k] = '0; m_dpp[k] = '0;
            m_pf[k] = 1'b0; m_t[k] = 0;
        end
    endfunction

    // One clock: queue what the coming edge must produce, advance the model, return at the next negedge.
    task automatic step();
        qa.push_back(model_out(0));
        qb.push_back(model_out(1));
        model_upd(0);
        model_upd(1);
        @(negedge clk);
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic step_load(input logic [31:0] d, input logic [7:0] p);
        data32 = d;
        dp8    = p;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic run_to_phase_a(input int p);
        for (int i = 0; i < 16 && (m_t[0] % 16) != p; i++) step();
    endtask

    task automatic check_reset_outputs();
        check("rst_anode_a",  {4'h0, anode_a}, 8'h0F);
        check("rst_catode_a", catode_a, 8'hFF);
        check("rst_anode_b",  anode_b,  8'hFF);
        check("rst_catode_b", catode_b, 8'hFF);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) seen_a[i] = 8'h00;
    endtask

    // Monitors: pop one expectation per edge that the driver queued
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a_anode",  {4'h0, anode_a}, e.an);
            check("a_catode", catode_a, e.ca);
            for (int i = 0; i < 4; i++)
                if (anode_a == 4'(~(4'b0001 << i))) seen_a[i] = catode_a;
        end
    end

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b_anode",  anode_b,  e.an);
            check("b_catode", catode_b, e.ca);
        end
    end

    initial begin
        reset    = 1'b1;
        data32   = '0;
        dp8      = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        enable   = 1'b1;
        model_reset();
        clear_seen();
        #3;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;

        step_n(20);

        // Mid-frame load commits only at the boundary
        run_to_phase_a(5);
        step_load(32'h0000_12AF, 8'b0010);
        run_to_phase_a(0);
        clear_seen();
        step_n(16);
        check("frame_d0", seen_a[0], 8'h8E);
        check("frame_d1", seen_a[1], 8'h08);
        check("frame_d2", seen_a[2], 8'hA4);
        check("frame_d3", seen_a[3], 8'hF9);

        // Load exactly on a boundary, then an overwritten pending value
        run_to_phase_a(15);
        step_load(32'h0000_0001, 8'h00);
        step_n(3);
        run_to_phase_a(2);
        step_load(32'h0000_1111, 8'h00);
        step_n(3);
        step_load(32'h0000_2222, 8'h00);
        run_to_phase_a(0);
        clear_seen();
        step_n(16);
        for (int i = 0; i < 4; i++) check("overwrite", seen_a[i], 8'hA4);

        // Leading-zero blanking
        blank_lz = 1'b1;
        run_to_phase_a(15);
        step_load(32'h0000_0030, 8'h00);
        clear_seen();
        step_n(16);
        check("lz_d3", seen_a[3], 8'hFF);
        check("lz_d2", seen_a[2], 8'hFF);
        check("lz_d1", seen_a[1], 8'hB0);
        check("lz_d0", seen_a[0], 8'hC0);
        run_to_phase_a(15);
        step_load(32'h0, 8'h00);
        step_n(17);
        blank_lz = 1'b0;

        // Enable off while scanning continues
        enable = 1'b0;
        step_n(11);
        enable = 1'b1;
        step_n(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            data32   = $urandom >> $urandom_range(0, 31);
            dp8      = 8'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            blank_lz = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 9) != 0);
            step();
            load = 1'b0;
        end
        enable   = 1'b1;
        blank_lz = 1'b0;
        run_to_phase_a(15);
        step_load(32'h0000_9876, 8'h0F);
        step_n(4);

        // Reset while a value is pending at digit index 2
        run_to_phase_a(9);
        step_load(32'h0000_4567, 8'h05);
        do_reset();
        step_n(20);

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
